// File: rtl/version_store_router.sv
// Registered version/data store with handshake writes, 1-cycle reads, oldest-entry replacement and clear sweep.
// Optional macro SNAPSHOT_READ_EN: reads return largest stored version <= requested version.
module version_store_router #(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4,
  parameter int VERSION_NUM   = 4,
  parameter int CNT_WIDTH     = $clog2(VERSION_NUM+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [VERSION_WIDTH-1:0] wr_version,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_drop,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [VERSION_WIDTH-1:0] rd_version,
  output logic                     rd_out_valid,
  output logic                     rd_hit,
  output logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     clr,
  output logic [CNT_WIDTH-1:0]     occupancy,
  output logic                     busy
);
  localparam int IDXW = $clog2(VERSION_NUM);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(VERSION_NUM-1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                                     state_q, state_d;
  logic [IDXW-1:0]                            idx_q, idx_d;
  logic [VERSION_NUM-1:0]                     valid_q, valid_d;
  logic [VERSION_NUM-1:0][VERSION_WIDTH-1:0]  ver_q, ver_d;
  logic [VERSION_NUM-1:0][DATA_WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0]                       occ_q, occ_d;
  logic                                       drop_q, drop_d;
  logic                                       busy_q;
  logic                                       rvld_q, rhit_q, rhit_d;
  logic [DATA_WIDTH-1:0]                      rdata_q, rdata_d;

  logic clr_slot;
  logic wr_fire, rd_fire;

  // FSM: ready is dropped already in the cycle clr is sampled
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    clr_slot = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_ready = !clr;
        rd_ready = !clr;
        if (clr) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        clr_slot = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_fire = wr_valid && wr_ready;
  assign rd_fire = rd_valid && rd_ready;

  logic                     hit_w, free_w, min_found;
  logic [IDXW-1:0]          hit_idx, free_idx, min_idx;
  logic [VERSION_WIDTH-1:0] min_ver;

  always_comb begin
    hit_w     = 1'b0;
    hit_idx   = '0;
    free_w    = 1'b0;
    free_idx  = '0;
    min_found = 1'b0;
    min_idx   = '0;
    min_ver   = '0;
    for (int i = 0; i < VERSION_NUM; i++) begin
      if (valid_q[i] && ver_q[i] == wr_version) begin
        hit_w   = 1'b1;
        hit_idx = IDXW'(i);
      end
      if (valid_q[i] && (!min_found || ver_q[i] < min_ver)) begin
        min_found = 1'b1;
        min_ver   = ver_q[i];
        min_idx   = IDXW'(i);
      end
    end
    // Descending scan so the lowest free index wins
    for (int i = VERSION_NUM-1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_w   = 1'b1;
        free_idx = IDXW'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    ver_d   = ver_q;
    data_d  = data_q;
    drop_d  = 1'b0;
    if (wr_fire) begin
      if (hit_w) begin
        data_d[hit_idx] = wr_data;
      end else if (free_w) begin
        valid_d[free_idx] = 1'b1;
        ver_d[free_idx]   = wr_version;
        data_d[free_idx]  = wr_data;
      end else if (wr_version > min_ver) begin
        ver_d[min_idx]  = wr_version;
        data_d[min_idx] = wr_data;
      end else begin
        drop_d = 1'b1;
      end
    end
    if (clr_slot) valid_d[idx_q] = 1'b0;
    occ_d = '0;
    for (int i = 0; i < VERSION_NUM; i++) occ_d = occ_d + CNT_WIDTH'(valid_d[i]);
  end

  // Lookup reads pre-write contents, giving read-before-write ordering
`ifdef SNAPSHOT_READ_EN
  logic [VERSION_WIDTH-1:0] best_ver;
  always_comb begin
    rhit_d   = 1'b0;
    rdata_d  = '0;
    best_ver = '0;
    for (int i = 0; i < VERSION_NUM; i++) begin
      if (valid_q[i] && ver_q[i] <= rd_version && (!rhit_d || ver_q[i] > best_ver)) begin
        rhit_d   = 1'b1;
        best_ver = ver_q[i];
        rdata_d  = data_q[i];
      end
    end
    if (!rd_fire) begin
      rhit_d  = 1'b0;
      rdata_d = '0;
    end
  end
`else
  always_comb begin
    rhit_d  = 1'b0;
    rdata_d = '0;
    for (int i = 0; i < VERSION_NUM; i++) begin
      if (rd_fire && valid_q[i] && ver_q[i] == rd_version) begin
        rhit_d  = 1'b1;
        rdata_d = data_q[i];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= '0;
      ver_q   <= '0;
      data_q  <= '0;
      occ_q   <= '0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
      rvld_q  <= 1'b0;
      rhit_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ver_q   <= ver_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
      drop_q  <= drop_d;
      busy_q  <= (state_d == S_CLEAR);
      rvld_q  <= rd_fire;
      rhit_q  <= rhit_d;
      rdata_q <= rdata_d;
    end
  end

  assign wr_drop      = drop_q;
  assign rd_out_valid = rvld_q;
  assign rd_hit       = rhit_q;
  assign rd_data      = rdata_q;
  assign occupancy    = occ_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_version_store_router.sv
// Random and directed checks of version_store_router against a version-keyed map model.
module tb_version_store_router;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, wr_ready, wr_drop;
  logic [3:0]  wr_version;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [3:0]  rd_version;
  logic        rd_out_valid, rd_hit;
  logic [31:0] rd_data;
  logic        clr;
  logic [2:0]  occupancy;
  logic        busy;

  version_store_router dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_version(wr_version),
    .wr_data(wr_data), .wr_drop(wr_drop),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_version(rd_version),
    .rd_out_valid(rd_out_valid), .rd_hit(rd_hit), .rd_data(rd_data),
    .clr(clr), .occupancy(occupancy), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: store contents as a map version -> data, capacity 4
  logic [31:0] mdl [int];
  bit          exp_hit, exp_drop;
  logic [31:0] exp_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void mdl_read(input int v, output bit hit, output logic [31:0] d);
    hit = 0;
    d   = '0;
`ifdef SNAPSHOT_READ_EN
    for (int k = v; k >= 0; k--) begin
      if (!hit && mdl.exists(k)) begin
        hit = 1;
        d   = mdl[k];
      end
    end
`else
    if (mdl.exists(v)) begin
      hit = 1;
      d   = mdl[v];
    end
`endif
  endfunction

  function automatic void mdl_write(input int v, input logic [31:0] d, output bit drop);
    int mn;
    drop = 0;
    if (mdl.exists(v) || mdl.num() < 4) begin
      mdl[v] = d;
    end else begin
      void'(mdl.first(mn));
      if (v > mn) begin
        mdl.delete(mn);
        mdl[v] = d;
      end else begin
        drop = 1;
      end
    end
  endfunction

  // One idle-state cycle: optional write and/or read, model updated read-before-write
  task automatic drive(input bit wv, input int wver, input logic [31:0] wd,
                       input bit rv, input int rver);
    wr_valid   = wv;
    wr_version = wver[3:0];
    wr_data    = wd;
    rd_valid   = rv;
    rd_version = rver[3:0];
    exp_hit  = 0;
    exp_data = '0;
    exp_drop = 0;
    if (rv) mdl_read(rver, exp_hit, exp_data);
    if (wv) mdl_write(wver, wd, exp_drop);
    step();
    wr_valid = 0;
    rd_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    mdl.delete();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    total++; if (rd_out_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", rd_out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_fill_read();
    drive(1, 3, 32'hAAAA, 0, 0);
    drive(1, 5, 32'hBBBB, 0, 0);
    drive(1, 1, 32'hCCCC, 0, 0);
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL fill_occ: got %0d want 3", occupancy); end
    drive(0, 0, 0, 1, 5);
    total++; if (rd_out_valid !== 1'b1) begin bad++; $display("FAIL read5_valid: got %b want 1", rd_out_valid); end
    total++; if (rd_hit !== 1'b1 || rd_data !== 32'hBBBB) begin bad++; $display("FAIL read5: got hit=%b data=%0h want hit=1 data=bbbb", rd_hit, rd_data); end
    drive(0, 0, 0, 1, 4);
    total++; if (rd_hit !== exp_hit || rd_data !== exp_data) begin bad++; $display("FAIL read4: got hit=%b data=%0h want hit=%b data=%0h", rd_hit, rd_data, exp_hit, exp_data); end
    step();
    total++; if (rd_out_valid !== 1'b0) begin bad++; $display("FAIL idle_rvalid: got %b want 0", rd_out_valid); end
  endtask

  task automatic test_replace();
    drive(1, 5, 32'h1234, 0, 0);
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL overwrite_occ: got %0d want 3", occupancy); end
    drive(0, 0, 0, 1, 5);
    total++; if (rd_hit !== 1'b1 || rd_data !== 32'h1234) begin bad++; $display("FAIL overwrite_read: got hit=%b data=%0h want 1/1234", rd_hit, rd_data); end
    drive(1, 7, 32'h7777, 0, 0);
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ: got %0d want 4", occupancy); end
    drive(1, 9, 32'h9999, 0, 0);
    total++; if (occupancy !== 3'd4 || wr_drop !== 1'b0) begin bad++; $display("FAIL evict: got occ=%0d drop=%b want 4/0", occupancy, wr_drop); end
    drive(0, 0, 0, 1, 1);
    total++; if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin bad++; $display("FAIL evicted_v1: got hit=%b data=%0h want 0/0", rd_hit, rd_data); end
    drive(0, 0, 0, 1, 9);
    total++; if (rd_hit !== 1'b1 || rd_data !== 32'h9999) begin bad++; $display("FAIL read9: got hit=%b data=%0h want 1/9999", rd_hit, rd_data); end
  endtask

  task automatic test_drop();
    drive(1, 2, 32'h2222, 0, 0);
    total++; if (wr_drop !== 1'b1) begin bad++; $display("FAIL drop_pulse: got %b want 1", wr_drop); end
    step();
    total++; if (wr_drop !== 1'b0) begin bad++; $display("FAIL drop_one_cycle: got %b want 0", wr_drop); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL drop_occ: got %0d want 4", occupancy); end
    drive(0, 0, 0, 1, 2);
    total++; if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin bad++; $display("FAIL drop_read2: got hit=%b data=%0h want 0/0", rd_hit, rd_data); end
  endtask

  task automatic test_back_to_back();
    drive(1, 6, 32'h6666, 1, 6);
    total++; if (rd_out_valid !== 1'b1 || rd_hit !== exp_hit || rd_data !== exp_data) begin bad++; $display("FAIL rbw_same: got v=%b hit=%b data=%0h want 1/%b/%0h", rd_out_valid, rd_hit, rd_data, exp_hit, exp_data); end
    drive(0, 0, 0, 1, 6);
    total++; if (rd_hit !== 1'b1 || rd_data !== 32'h6666) begin bad++; $display("FAIL rbw_next: got hit=%b data=%0h want 1/6666", rd_hit, rd_data); end
  endtask

  task automatic test_random();
    bit wv, rv;
    int wver, rver;
    logic [31:0] wd;
    for (int n = 0; n < 300; n++) begin
      wv   = ($urandom_range(0, 3) != 0);
      rv   = ($urandom_range(0, 1) != 0);
      wver = $urandom_range(0, 15);
      rver = $urandom_range(0, 15);
      wd   = $urandom;
      drive(wv, wver, wd, rv, rver);
      total++; if (rd_out_valid !== rv) begin bad++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", n, rd_out_valid, rv); end
      if (rv) begin
        total++; if (rd_hit !== exp_hit || rd_data !== exp_data) begin bad++; $display("FAIL rnd_read[%0d] v%0d: got hit=%b data=%0h want %b/%0h", n, rver, rd_hit, rd_data, exp_hit, exp_data); end
      end
      total++; if (wr_drop !== exp_drop) begin bad++; $display("FAIL rnd_drop[%0d]: got %b want %b", n, wr_drop, exp_drop); end
      total++; if (int'(occupancy) != mdl.num()) begin bad++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", n, occupancy, mdl.num()); end
    end
  endtask

  task automatic test_clear();
    int n;
    bit any_hit;
    clr      = 1;
    wr_valid = 1;
    wr_version = 4'd8;
    wr_data  = 32'hDEAD;
    #1;
    total++; if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin bad++; $display("FAIL clr_sample_ready: got wr=%b rd=%b want 0/0", wr_ready, rd_ready); end
    step();
    clr      = 0;
    wr_valid = 0;
    rd_valid = 1;
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      total++; if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin bad++; $display("FAIL clear_ready[%0d]: got wr=%b rd=%b want 0/0", n, wr_ready, rd_ready); end
      n++;
      step();
    end
    rd_valid = 0;
    mdl.delete();
    total++; if (n != 4) begin bad++; $display("FAIL clear_len: got %0d want 4", n); end
    total++; if (rd_out_valid !== 1'b0) begin bad++; $display("FAIL clear_no_read: got %b want 0", rd_out_valid); end
    total++; if (occupancy !== 3'd0 || wr_ready !== 1'b1) begin bad++; $display("FAIL clear_done: got occ=%0d wr_ready=%b want 0/1", occupancy, wr_ready); end
    any_hit = 0;
    for (int v = 0; v < 16; v++) begin
      drive(0, 0, 0, 1, v);
      if (rd_hit !== 1'b0) any_hit = 1;
    end
    total++; if (any_hit) begin bad++; $display("FAIL clear_reads: got a hit want all miss"); end
  endtask

  task automatic test_reset_mid_clear();
    drive(1, 4, 32'h4444, 0, 0);
    drive(1, 11, 32'hBBBB, 0, 0);
    clr = 1;
    step();
    clr = 0;
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midclr_busy: got %b want 1", busy); end
    rst = 1;
    step();
    rst = 0;
    mdl.delete();
    total++; if (busy !== 1'b0 || wr_ready !== 1'b1 || occupancy !== 3'd0) begin bad++; $display("FAIL midclr_reset: got busy=%b wr_ready=%b occ=%0d want 0/1/0", busy, wr_ready, occupancy); end
    drive(0, 0, 0, 1, 11);
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL midclr_read: got hit=%b want 0", rd_hit); end
  endtask

  initial begin
    rst = 1; clr = 0;
    wr_valid = 0; wr_version = 0; wr_data = 0;
    rd_valid = 0; rd_version = 0;
    test_reset();
    test_fill_read();
    test_replace();
    test_drop();
    test_back_to_back();
    test_random();
    test_clear();
    test_random();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/version_store_router.md
Name: version_store_router

Overview:
- Sequential successor to the combinational version-priority router.
- Holds up to VERSION_NUM (version, data) entries in registers. Writes arrive through a valid/ready handshake. Reads look up a requested version and return a registered result one cycle later.
- Adds replacement of the oldest entry, a multi-cycle clear sweep, and occupancy tracking.
- Sits between the version producers and the consumers that read by version.

Parameters:
- DATA_WIDTH, 32, width of each stored data word
- VERSION_WIDTH, 4, width of a version tag (unsigned)
- VERSION_NUM, 4, number of entry slots (>=2)
- CNT_WIDTH, $clog2(VERSION_NUM+1), width of the occupancy count

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_version  in  VERSION_WIDTH  version tag to write
- wr_data  in  DATA_WIDTH  data to write
- wr_drop  out  1  one-cycle pulse: accepted write discarded (older than every stored entry, store full)
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted when rd_valid && rd_ready
- rd_version  in  VERSION_WIDTH  version requested
- rd_out_valid  out  1  registered response strobe
- rd_hit  out  1  response found a matching entry
- rd_data  out  DATA_WIDTH  response data; 0 on miss
- clr  in  1  start clear sweep (level sampled in IDLE)
- occupancy  out  CNT_WIDTH  number of valid entries
- busy  out  1  high while in CLEAR

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; rst wins over every other input.
- Reset values:
  - all slot valid bits 0; slot version and data 0
  - occupancy=0, rd_out_valid=0, rd_hit=0, rd_data=0, wr_drop=0, busy=0
  - FSM=IDLE
- FSM states:
  - IDLE:
    - wr_ready=1, rd_ready=1
    - clr=1 -> CLEAR with sweep index 0; a write or read presented in the same cycle is not accepted (ready already low that cycle).
  - CLEAR:
    - wr_ready=0, rd_ready=0, busy=1
    - clears one slot's valid bit per cycle, index 0..VERSION_NUM-1
    - returns to IDLE the cycle after clearing the last index; sweep takes VERSION_NUM cycles
    - clr is ignored while in CLEAR
- Ready timing: wr_ready and rd_ready are combinational from the FSM state, low in the clr-sampling cycle.
- Write, on an accepted write:
  - Version already stored: overwrite that slot's data; occupancy unchanged.
  - Else, a free slot exists: fill the lowest-index free slot; occupancy+1.
  - Else (store full) and wr_version > minimum stored version: replace the slot holding the minimum version; occupancy unchanged.
  - Else (full, wr_version < minimum): discard; wr_drop=1 for the next cycle only.
- Version ordering and uniqueness: comparisons are unsigned with no wrap-around handling. Stored versions are always unique.
- Read:
  - Accepted read -> rd_out_valid=1 exactly one cycle later, with rd_hit/rd_data.
  - rd_out_valid is 0 in every cycle without an accepted read the cycle before.
  - Default (exact-match) lookup: hit if some valid slot version == rd_version.
- Simultaneous read and write in one cycle: the read sees contents before the write (read-before-write).
- Outputs: all outputs except wr_ready and rd_ready are registered.
- Reset mid-CLEAR: FSM -> IDLE and all state cleared as above.

Optional Feature:
- Macro: SNAPSHOT_READ_EN
- Defined: read returns the valid entry with the largest version <= rd_version (snapshot semantics).
  - rd_hit=0 only when no valid entry satisfies that condition.
  - The selection is a registered priority compare across slots; latency stays 1 cycle.
- Undefined: exact-match lookup only; no magnitude comparator on the read path.

Test Plan:
- Reset: assert rst 2 cycles -> occupancy=0, rd_out_valid=0, busy=0, wr_ready=1.
- Fill and read:
  - write (v3,0xAAAA),(v5,0xBBBB),(v1,0xCCCC) -> occupancy=3
  - read v5 -> next cycle rd_out_valid=1, rd_hit=1, rd_data=0xBBBB
  - read v4 -> rd_hit=0, rd_data=0 (exact); with SNAPSHOT_READ_EN, rd_hit=1, rd_data=0xAAAA
- Overwrite and replacement:
  - write (v5,0x1234) -> occupancy unchanged; read v5 returns 0x1234
  - fill to 4 with (v7,0x7777), then write (v9,0x9999) -> v1 evicted; read v1 misses; read v9 returns 0x9999
- Drop: store full holding v3,v5,v7,v9; write (v2,0x2222) -> wr_drop pulses 1 cycle, occupancy=4, read v2 misses.
- Read-before-write: same cycle write (v6,0x6666) and read v6 -> response rd_hit=0; read v6 one cycle later -> hit, 0x6666.
- Clear:
  - pulse clr -> busy=1 and wr_ready=rd_ready=0 for exactly 4 cycles, then occupancy=0 and all reads miss
  - assert rst during CLEAR -> next cycle IDLE, busy=0
